bicintp_eng_dda: RTL and testbench
==================================

Name: bicintp_eng_dda

Overview:
Parametrised successor of the fixed 640x480->1024x768 bicubic sequencer. A DDA phase accumulator replaces the hard-wired 8-phase pattern, so any runtime source/destination size is supported.
For each destination pixel the block generates TAPS clamped source-line-RAM read addresses, horizontal and vertical coefficient ROM addresses, and line-advance requests to the line buffer. It also produces the pipeline-aligned interpolation enable for the bicubic calculator.
Sits between the CMOS line-buffer RAM/coef ROMs and the bicintp calculator.

Parameters:
TAPS, 4, taps per axis; power of 2, 2..8
PH_BITS, 3, coefficient phase bits; 2^PH_BITS phases per axis
FRAC_BITS, 16, DDA fractional bits; must be >= PH_BITS
CNT_W, 12, width of size configs and pixel/line counters
ADDR_W, 10, line-RAM address width
PIPE_LAT, 3, cycles from INTP state to intp_enb

Ports:
sys_clk  in  1  single clock
sys_rst  in  1  synchronous, active-high reset
frame_start  in  1  pulse; latches cfg_* while in IDLE, ignored otherwise
cfg_src_w, cfg_src_h  in  CNT_W each  source size
cfg_dst_w, cfg_dst_h  in  CNT_W each  destination size
cfg_h_step, cfg_v_step  in  CNT_W+FRAC_BITS each  src/dst ratio, unsigned fixed point
line_ready  in  1  line buffer holds the TAPS source lines for the current v position
ram_rd_enb  out  1  line-RAM read strobe
ram_rd_addr  out  ADDR_W  clamped source column
ram_rd_tap  out  log2(TAPS)  tap index of the current read
coef_h_addr  out  PH_BITS+log2(TAPS)  {h_phase, tap}
coef_v_addr  out  PH_BITS+log2(TAPS)  {v_phase, tap}
coef_v_rd_enb  out  1  vertical coefficient fetch strobe
line_adv  out  1  pulse; source lines consumed
line_adv_cnt  out  4  number of lines consumed, valid with line_adv
intp_enb  out  1  calculator enable
busy  out  1  FSM not in IDLE
frame_done  out  1  one-cycle pulse at end of frame
cfg_err  out  1  sticky until next frame_start; zero dst size requested

Behaviour:
- Reset: FSM=IDLE and every output 0, including cfg_err. Registers, accumulators and sub_cnt all clear. Reset mid-frame aborts immediately; a new frame_start is required.
- IDLE:
  - frame_start latches cfg_*.
  - If cfg_dst_w==0 or cfg_dst_h==0: set cfg_err and stay IDLE.
  - Otherwise load h_acc/v_acc with the initial value, set pix=0 and line=0, go to WAIT.
- WAIT -> PRE when line_ready=1.
- PRE (TAPS cycles, sub_cnt 0..TAPS-1): coef_v_rd_enb=1, coef_v_addr={v_phase, sub_cnt}. After the last tap go to INTP.
- INTP (TAPS cycles per destination pixel):
  - ram_rd_tap=sub_cnt and coef_h_addr={h_phase, sub_cnt} are combinational.
  - Column = h_int - (TAPS/2-1) + sub_cnt, computed signed, then clamped: <0 -> 0, >cfg_src_w-1 -> cfg_src_w-1.
  - ram_rd_addr/ram_rd_enb are registered, so they appear 1 cycle after their sub_cnt.
  - At sub_cnt==TAPS-1: h_acc += cfg_h_step and pix++.
  - On the last pixel (pix==cfg_dst_w-1):
    - Reload h_acc and increment line.
    - Compute v_new = v_acc + cfg_v_step.
    - Pulse line_adv, with line_adv_cnt = int(v_new) - int(v_acc), saturated at 15.
    - If line==cfg_dst_h-1: frame_done pulse, go to IDLE.
    - Otherwise go to BLANK.
- BLANK (minimum 1 cycle):
  - If the last line_adv_cnt==0, go to PRE next cycle regardless of line_ready.
  - Otherwise wait for line_ready, then go to PRE.
- Accumulators: signed, CNT_W+FRAC_BITS+1 bits; overflow wrap is not checked.
  - int = acc >>> FRAC_BITS.
  - phase = acc[FRAC_BITS-1 : FRAC_BITS-PH_BITS].
  - A negative v int clamps to row 0 for line-advance accounting.
- intp_enb = (FSM==INTP) delayed PIPE_LAT cycles. It is cleared by reset.
- busy = (FSM != IDLE).
- Simultaneous events:
  - frame_start outside IDLE is ignored.
  - line_ready arriving in the same cycle a BLANK/WAIT state is entered takes effect that cycle (transition on the next edge).

Optional Feature:
BICINTP_CENTER_ALIGN_EN:
- Defined: initial acc = (step>>1) - 2^(FRAC_BITS-1), i.e. pixel-centre alignment; may be negative.
- Undefined: initial acc = 0, top-left alignment.
- The macro affects only the initial load.

Test Plan:
1. Scaling case: cfg 640x480->1024x768, h/v_step=40960, macro off.
   - Pixel 0: ram_rd_addr 0,0,1,2.
   - Pixel 1: ram_rd_addr 0,0,1,2 and coef_h_addr phase 5.
   - intp_enb rises 3 cycles after INTP entry.
2. Right edge, same cfg: pixel 1023 (acc=41902080, int 639, phase 3) -> ram_rd_addr 638,639,639,639.
3. Line advance, same cfg:
   - End of line 0: line_adv cnt 0, BLANK->PRE in 1 cycle with line_ready=0.
   - End of line 1: cnt 1, FSM holds in BLANK until line_ready.
4. Downscale: 640->320, step=131072 -> every line end gives line_adv_cnt=2; pixel n first address clamp(2n-1).
5. Reset abort: sys_rst=1 mid-INTP -> next cycle all outputs 0, IDLE; frame_start with cfg_dst_w=0 -> cfg_err=1, busy stays 0.
6. Frame end: last pixel of line cfg_dst_h-1 -> frame_done 1-cycle pulse, IDLE, intp_enb falls PIPE_LAT cycles after INTP exit. With macro on, step 40960 gives initial acc=-12288 -> pixel 0 addresses 0,0,0,1.

Source files
------------

// File: rtl/bicintp_eng_dda.sv
// bicintp_eng_dda: DDA-driven bicubic sequencer. For every destination pixel
// it issues TAPS clamped line-RAM reads, horizontal/vertical coefficient ROM
// addresses, line-advance requests and the pipeline-aligned calculator enable.
// Build option: define BICINTP_CENTER_ALIGN_EN to load the accumulators with
// pixel-centre alignment ((step>>1) - 0.5); otherwise they start at 0.
module bicintp_eng_dda #(
  parameter int unsigned TAPS      = 4,
  parameter int unsigned PH_BITS   = 3,
  parameter int unsigned FRAC_BITS = 16,
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned PIPE_LAT  = 3
) (
  input  logic                                sys_clk,
  input  logic                                sys_rst,
  input  logic                                frame_start,
  input  logic [CNT_W-1:0]                    cfg_src_w,
  input  logic [CNT_W-1:0]                    cfg_src_h,
  input  logic [CNT_W-1:0]                    cfg_dst_w,
  input  logic [CNT_W-1:0]                    cfg_dst_h,
  input  logic [CNT_W+FRAC_BITS-1:0]          cfg_h_step,
  input  logic [CNT_W+FRAC_BITS-1:0]          cfg_v_step,
  input  logic                                line_ready,
  output logic                                ram_rd_enb,
  output logic [ADDR_W-1:0]                   ram_rd_addr,
  output logic [$clog2(TAPS)-1:0]             ram_rd_tap,
  output logic [PH_BITS+$clog2(TAPS)-1:0]     coef_h_addr,
  output logic [PH_BITS+$clog2(TAPS)-1:0]     coef_v_addr,
  output logic                                coef_v_rd_enb,
  output logic                                line_adv,
  output logic [3:0]                          line_adv_cnt,
  output logic                                intp_enb,
  output logic                                busy,
  output logic                                frame_done,
  output logic                                cfg_err
);

  localparam int unsigned TW = $clog2(TAPS);
  localparam int unsigned SW = CNT_W + FRAC_BITS;
  localparam int unsigned AW = CNT_W + FRAC_BITS + 1;
  localparam logic [AW-1:0] HALF_PIX = AW'(1) << (FRAC_BITS - 1);
  localparam logic signed [AW-1:0] SAT15 = AW'(15);
`ifdef BICINTP_CENTER_ALIGN_EN
  localparam bit CENTRE_ALIGN = 1'b1;
`else
  localparam bit CENTRE_ALIGN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_PRE, S_INTP, S_BLANK} state_t;

  state_t                 state_q;
  logic [TW-1:0]          sub_q;
  logic [CNT_W-1:0]       pix_q, line_q;
  logic signed [AW-1:0]   h_acc_q, v_acc_q;
  logic [CNT_W-1:0]       cfg_src_w_q, cfg_dst_w_q, cfg_dst_h_q;
  logic [SW-1:0]          cfg_h_step_q, cfg_v_step_q;
  logic                   adv_zero_q;
  logic                   ram_rd_enb_q, line_adv_q, frame_done_q, cfg_err_q;
  logic [ADDR_W-1:0]      ram_rd_addr_q;
  logic [3:0]             line_adv_cnt_q;
  logic [PIPE_LAT-1:0]    ipipe_q;

  logic [ADDR_W-1:0]      ram_rd_addr_d;
  logic [3:0]             line_adv_cnt_d;
  logic signed [AW-1:0]   v_acc_d;
  logic signed [AW:0]     col_s, src_max_s;
  logic signed [AW-1:0]   v_int_cur, v_int_new, v_diff;
  logic                   sub_last, pix_last, line_last;

  // Source height is not needed here: vertical edge handling lives in the line buffer.
  logic unused_cfg_src_h;
  assign unused_cfg_src_h = ^cfg_src_h;

  // Initial accumulator value; the build option only changes this load.
  function automatic logic [AW-1:0] init_acc(input logic [SW-1:0] step);
    logic [AW-1:0] centre;
    centre = ({1'b0, step} >> 1) - HALF_PIX;
    return CENTRE_ALIGN ? centre : '0;
  endfunction

  assign sub_last  = (sub_q == TW'(TAPS - 1));
  assign pix_last  = (pix_q == cfg_dst_w_q - CNT_W'(1));
  assign line_last = (line_q == cfg_dst_h_q - CNT_W'(1));

  // Clamped source column for the current tap and line-advance count.
  always_comb begin
    col_s     = ($signed({h_acc_q[AW-1], h_acc_q}) >>> FRAC_BITS)
                - $signed((AW+1)'(TAPS/2 - 1)) + $signed((AW+1)'(sub_q));
    src_max_s = $signed((AW+1)'(cfg_src_w_q)) - $signed((AW+1)'(1));
    if (col_s[AW])
      ram_rd_addr_d = '0;
    else if (col_s > src_max_s)
      ram_rd_addr_d = src_max_s[ADDR_W-1:0];
    else
      ram_rd_addr_d = col_s[ADDR_W-1:0];

    v_acc_d   = v_acc_q + $signed({1'b0, cfg_v_step_q});
    v_int_cur = v_acc_q >>> FRAC_BITS;
    v_int_new = v_acc_d >>> FRAC_BITS;
    // Rows above the image all map to row 0, so they consume no lines.
    if (v_int_cur[AW-1]) v_int_cur = '0;
    if (v_int_new[AW-1]) v_int_new = '0;
    v_diff = v_int_new - v_int_cur;
    if (v_diff[AW-1])
      line_adv_cnt_d = '0;
    else if (v_diff > SAT15)
      line_adv_cnt_d = 4'd15;
    else
      line_adv_cnt_d = v_diff[3:0];
  end

  // Sequencer FSM with registered read/advance/status outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= S_IDLE;
      sub_q          <= '0;
      pix_q          <= '0;
      line_q         <= '0;
      h_acc_q        <= '0;
      v_acc_q        <= '0;
      cfg_src_w_q    <= '0;
      cfg_dst_w_q    <= '0;
      cfg_dst_h_q    <= '0;
      cfg_h_step_q   <= '0;
      cfg_v_step_q   <= '0;
      adv_zero_q     <= 1'b0;
      ram_rd_enb_q   <= 1'b0;
      ram_rd_addr_q  <= '0;
      line_adv_q     <= 1'b0;
      line_adv_cnt_q <= '0;
      frame_done_q   <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      ram_rd_enb_q <= 1'b0;
      line_adv_q   <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            cfg_src_w_q  <= cfg_src_w;
            cfg_dst_w_q  <= cfg_dst_w;
            cfg_dst_h_q  <= cfg_dst_h;
            cfg_h_step_q <= cfg_h_step;
            cfg_v_step_q <= cfg_v_step;
            if (cfg_dst_w == '0 || cfg_dst_h == '0) begin
              cfg_err_q <= 1'b1;
            end else begin
              cfg_err_q <= 1'b0;
              h_acc_q   <= init_acc(cfg_h_step);
              v_acc_q   <= init_acc(cfg_v_step);
              pix_q     <= '0;
              line_q    <= '0;
              sub_q     <= '0;
              state_q   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (line_ready) begin
            sub_q   <= '0;
            state_q <= S_PRE;
          end
        end
        S_PRE: begin
          if (sub_last) begin
            sub_q   <= '0;
            state_q <= S_INTP;
          end else begin
            sub_q <= sub_q + TW'(1);
          end
        end
        S_INTP: begin
          ram_rd_enb_q  <= 1'b1;
          ram_rd_addr_q <= ram_rd_addr_d;
          if (sub_last) begin
            sub_q <= '0;
            if (pix_last) begin
              pix_q          <= '0;
              h_acc_q        <= init_acc(cfg_h_step_q);
              line_q         <= line_q + CNT_W'(1);
              v_acc_q        <= v_acc_d;
              line_adv_q     <= 1'b1;
              line_adv_cnt_q <= line_adv_cnt_d;
              adv_zero_q     <= (line_adv_cnt_d == '0);
              if (line_last) begin
                frame_done_q <= 1'b1;
                state_q      <= S_IDLE;
              end else begin
                state_q <= S_BLANK;
              end
            end else begin
              h_acc_q <= h_acc_q + $signed({1'b0, cfg_h_step_q});
              pix_q   <= pix_q + CNT_W'(1);
            end
          end else begin
            sub_q <= sub_q + TW'(1);
          end
        end
        S_BLANK: begin
          // No lines consumed means the buffer already holds the next window.
          if (adv_zero_q || line_ready) begin
            sub_q   <= '0;
            state_q <= S_PRE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Calculator enable: INTP occupancy delayed to match the datapath latency.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ipipe_q <= '0;
    end else begin
      ipipe_q[0] <= (state_q == S_INTP);
      for (int unsigned i = 1; i < PIPE_LAT; i++) ipipe_q[i] <= ipipe_q[i-1];
    end
  end

  assign ram_rd_enb    = ram_rd_enb_q;
  assign ram_rd_addr   = ram_rd_addr_q;
  assign ram_rd_tap    = sub_q;
  assign coef_h_addr   = {h_acc_q[FRAC_BITS-1 -: PH_BITS], sub_q};
  assign coef_v_addr   = {v_acc_q[FRAC_BITS-1 -: PH_BITS], sub_q};
  assign coef_v_rd_enb = (state_q == S_PRE);
  assign line_adv      = line_adv_q;
  assign line_adv_cnt  = line_adv_cnt_q;
  assign intp_enb      = ipipe_q[PIPE_LAT-1];
  assign busy          = (state_q != S_IDLE);
  assign frame_done    = frame_done_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_bicintp_eng_dda.sv
// tb_bicintp_eng_dda: directed, table-driven bench for the bicubic DDA sequencer.
module tb_bicintp_eng_dda;
  localparam int unsigned TAPS = 4, PH_BITS = 3, FRAC_BITS = 16;
  localparam int unsigned CNT_W = 12, ADDR_W = 10, PIPE_LAT = 3;

  logic        clk = 1'b0;
  logic        rst, frame_start, line_ready;
  logic [11:0] src_w, src_h, dst_w, dst_h;
  logic [27:0] h_step, v_step;
  logic        ram_rd_enb, coef_v_rd_enb, line_adv, intp_enb, busy, frame_done, cfg_err;
  logic [9:0]  ram_rd_addr;
  logic [1:0]  ram_rd_tap;
  logic [4:0]  coef_h_addr, coef_v_addr;
  logic [3:0]  line_adv_cnt;

  always #5 clk = ~clk;

  bicintp_eng_dda #(
    .TAPS(TAPS), .PH_BITS(PH_BITS), .FRAC_BITS(FRAC_BITS),
    .CNT_W(CNT_W), .ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .frame_start(frame_start),
    .cfg_src_w(src_w), .cfg_src_h(src_h), .cfg_dst_w(dst_w), .cfg_dst_h(dst_h),
    .cfg_h_step(h_step), .cfg_v_step(v_step), .line_ready(line_ready),
    .ram_rd_enb(ram_rd_enb), .ram_rd_addr(ram_rd_addr), .ram_rd_tap(ram_rd_tap),
    .coef_h_addr(coef_h_addr), .coef_v_addr(coef_v_addr), .coef_v_rd_enb(coef_v_rd_enb),
    .line_adv(line_adv), .line_adv_cnt(line_adv_cnt), .intp_enb(intp_enb),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  // Expected values that depend on the alignment build option.
`ifdef BICINTP_CENTER_ALIGN_EN
  localparam int P0 = 6, P1 = 3, P1023 = 1, PD = 4, A02 = 0, A03 = 1, VPH = 6;
`else
  localparam int P0 = 0, P1 = 5, P1023 = 3, PD = 0, A02 = 1, A03 = 2, VPH = 0;
`endif

  typedef struct { int set; int idx; int addr; int tap; int phase; } vec_t;
  typedef struct { int addr; int tap; int phase; } rd_t;

  vec_t vec[18];
  rd_t  rd_q[$];
  int   adv_cnt_q[$], adv_t_q[$], fd_t_q[$];
  int   cyc = 0;
  int   entry_t, ie_rise_t, ie_fall_t, cv_rise_t;
  logic [4:0] prev_ch = '0;
  logic [1:0] prev_tap = '0;
  logic prev_cv = 1'b0, prev_ie = 1'b0;
  int   n_chk = 0, n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Records reads (paired with the tap/coef of the INTP cycle that issued them) and events.
  always @(negedge clk) begin : mon
    rd_t r;
    if (ram_rd_enb) begin
      r.addr = int'(ram_rd_addr); r.tap = int'(prev_tap); r.phase = int'(prev_ch[4:2]);
      rd_q.push_back(r);
    end
    if (line_adv) begin adv_cnt_q.push_back(int'(line_adv_cnt)); adv_t_q.push_back(cyc); end
    if (frame_done) fd_t_q.push_back(cyc);
    if (prev_cv && !coef_v_rd_enb && entry_t < 0) entry_t = cyc;
    if (!prev_cv && coef_v_rd_enb) cv_rise_t = cyc;
    if (!prev_ie && intp_enb && ie_rise_t < 0) ie_rise_t = cyc;
    if (prev_ie && !intp_enb) ie_fall_t = cyc;
    prev_ch = coef_h_addr; prev_tap = ram_rd_tap;
    prev_cv = coef_v_rd_enb; prev_ie = intp_enb;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic int adv_at(input int i);
    return (i < adv_cnt_q.size()) ? adv_cnt_q[i] : -1;
  endfunction

  function automatic int advt_at(input int i);
    return (i < adv_t_q.size()) ? adv_t_q[i] : -1;
  endfunction

  // Read records encoded as addr*100 + tap*10 + phase.
  task automatic check_set(input int s);
    int got;
    for (int i = 0; i < 18; i++) begin
      if (vec[i].set == s) begin
        got = (vec[i].idx < rd_q.size()) ?
              rd_q[vec[i].idx].addr * 100 + rd_q[vec[i].idx].tap * 10 + rd_q[vec[i].idx].phase : -1;
        check($sformatf("rd[%0d]", vec[i].idx), got,
              vec[i].addr * 100 + vec[i].tap * 10 + vec[i].phase);
      end
    end
  endtask

  task automatic clear_mon();
    rd_q.delete(); adv_cnt_q.delete(); adv_t_q.delete(); fd_t_q.delete();
    entry_t = -1; ie_rise_t = -1; ie_fall_t = -1; cv_rise_t = -1;
  endtask

  function automatic logic [32:0] all_outs();
    return {ram_rd_enb, ram_rd_addr, ram_rd_tap, coef_h_addr, coef_v_addr, coef_v_rd_enb,
            line_adv, line_adv_cnt, intp_enb, busy, frame_done, cfg_err};
  endfunction

  initial begin
    int hold_cv, t_fd;
    // set 0: 640->1024 upscale, line 0; set 1: 2:1 downscale
    vec[0]  = '{0, 0,    0,   0, P0};
    vec[1]  = '{0, 1,    0,   1, P0};
    vec[2]  = '{0, 2,    A02, 2, P0};
    vec[3]  = '{0, 3,    A03, 3, P0};
    vec[4]  = '{0, 4,    0,   0, P1};
    vec[5]  = '{0, 5,    0,   1, P1};
    vec[6]  = '{0, 6,    1,   2, P1};
    vec[7]  = '{0, 7,    2,   3, P1};
    vec[8]  = '{0, 4092, 638, 0, P1023};
    vec[9]  = '{0, 4093, 639, 1, P1023};
    vec[10] = '{0, 4094, 639, 2, P1023};
    vec[11] = '{0, 4095, 639, 3, P1023};
    vec[12] = '{1, 0,    0,   0, PD};
    vec[13] = '{1, 4,    1,   0, PD};
    vec[14] = '{1, 8,    3,   0, PD};
    vec[15] = '{1, 12,   5,   0, PD};
    vec[16] = '{1, 1276, 637, 0, PD};
    vec[17] = '{1, 1279, 639, 3, PD};

    rst = 1'b1; frame_start = 1'b0; line_ready = 1'b0;
    src_w = '0; src_h = '0; dst_w = '0; dst_h = '0; h_step = '0; v_step = '0;
    clear_mon();
    repeat (3) tick();
    rst = 1'b0; tick();
    check("reset_outs", all_outs(), 0);

    // Upscale 640x480 -> 1024x768
    src_w = 12'd640; src_h = 12'd480; dst_w = 12'd1024; dst_h = 12'd768;
    h_step = 28'd40960; v_step = 28'd40960;
    frame_start = 1'b1; line_ready = 1'b1; tick();
    frame_start = 1'b0;
    check("busy_after_start", busy, 1);
    tick();
    line_ready = 1'b0;
    check("pre_tap0", {coef_v_rd_enb, coef_v_addr}, {1'b1, 5'(VPH * 4)});
    tick();
    check("pre_tap1", {coef_v_rd_enb, coef_v_addr}, {1'b1, 5'(VPH * 4 + 1)});
    for (int k = 0; k < 5000 && adv_cnt_q.size() < 1; k++) tick();
    check("line0_adv_cnt", adv_at(0), 0);
    tick(); tick();
    check("blank_skip_1cyc", cv_rise_t, advt_at(0) + 1);
    check("intp_enb_latency", ie_rise_t, entry_t + 3);
    check_set(0);
    for (int k = 0; k < 5000 && adv_cnt_q.size() < 2; k++) tick();
    check("line1_adv_cnt", adv_at(1), 1);
    hold_cv = cv_rise_t;
    repeat (10) tick();
    check("blank_hold_busy", busy, 1);
    check("blank_hold_no_pre", cv_rise_t, hold_cv);
    line_ready = 1'b1; tick();
    check("blank_release", coef_v_rd_enb, 1);
    repeat (8) tick();
    check("mid_intp_reading", ram_rd_enb, 1);
    rst = 1'b1; tick();
    check("reset_abort_outs", all_outs(), 0);
    rst = 1'b0; line_ready = 1'b0; tick();

    // Zero destination width
    dst_w = 12'd0; frame_start = 1'b1; tick();
    frame_start = 1'b0;
    check("cfg_err_set", cfg_err, 1);
    check("cfg_err_idle", busy, 0);
    repeat (3) tick();
    check("cfg_err_sticky", cfg_err, 1);

    // Downscale 2:1, 320x3 destination, full frame
    clear_mon();
    dst_w = 12'd320; dst_h = 12'd3; h_step = 28'd131072; v_step = 28'd131072;
    frame_start = 1'b1; line_ready = 1'b1; tick();
    frame_start = 1'b0;
    check("cfg_err_cleared", cfg_err, 0);
    repeat (20) tick();
    dst_w = 12'd0; frame_start = 1'b1; tick();
    frame_start = 1'b0;
    for (int k = 0; k < 6000 && fd_t_q.size() < 1; k++) tick();
    repeat (6) tick();
    check("fd_count", fd_t_q.size(), 1);
    t_fd = (fd_t_q.size() > 0) ? fd_t_q[0] : -100;
    for (int i = 0; i < 3; i++) check($sformatf("down_adv%0d", i), adv_at(i), 2);
    check("fd_with_last_adv", t_fd, advt_at(2));
    check("idle_after_frame", {busy, cfg_err, frame_done}, 0);
    check("intp_enb_fall", ie_fall_t, t_fd + 3);
    check("down_read_count", rd_q.size(), 3 * 320 * 4);
    check_set(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
